// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared state enum, error-flag struct and limits for the UART receiver
package uart_pkg;

  localparam int MIN_DATA_BITS = 5;
  localparam int MIN_OSR       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic brk;
    logic framing;
    logic parity;
  } rx_err_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive FIFO read port shared by the receiver and its consumer
interface uart_rx_fifo_if #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16
);
  import uart_pkg::*;

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  rx_err_t           rd_err;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              overrun;

  modport slave  (input  rd_en, output rd_data, rd_err, empty, full, level, overrun);
  modport master (output rd_en, input  rd_data, rd_err, empty, full, level, overrun);

endinterface

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - synchronous show-ahead FIFO with occupancy and overrun pulse
module uart_rx_fifo_mem #(
  parameter  int WIDTH  = 12,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LVL_W  = ADDR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level,
  output logic             o_overrun
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overrun;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_push && !w_do_push;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampled UART receiver feeding a show-ahead FIFO; UART_RX_MAJORITY_EN enables 3-tick majority voting
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int OSR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             rx_enable,
  input  logic [3:0]       data_len,
  input  logic             parity_enable,
  input  logic             parity_odd,
  input  logic             stop_2,
  input  logic             osr_tick,
  input  logic [OSR_W-1:0] osr_value,
  input  logic             rxd,
  output logic             busy,
  uart_rx_fifo_if.slave    rd_if
);

  localparam int ENTRY_W = DATA_W + 3;

  rx_state_t          r_state;
  rx_state_t          w_state_nx;
  logic               r_rxd_meta;
  logic               r_rxd_sync;
  logic               r_rxd_prev;
  logic [OSR_W-1:0]   r_tick_cnt;
  logic [3:0]         r_bit_idx;
  logic [DATA_W-1:0]  r_data;
  logic               r_par;
  logic               r_par_err;
  logic               r_framing;
  logic               r_all_zero;
  logic               r_stop_idx;
  logic               r_push_pend;
  logic [ENTRY_W-1:0] r_entry;

  logic [3:0]         w_eff_len;
  logic [OSR_W-1:0]   w_eff_osr;
  logic [OSR_W-1:0]   w_mid;
  logic [OSR_W-1:0]   w_start_pt;
  logic [OSR_W-1:0]   w_cnt_next;
  logic               w_run;
  logic               w_fall;
  logic               w_bit_val;
  logic               w_start_hit;
  logic               w_bit_hit;
  logic               w_hit;
  logic               w_last_bit;
  logic               w_brk_now;
  logic               w_push_now;
  rx_err_t            w_err;
  logic [ENTRY_W-1:0] w_rd_entry;

  always_comb begin
    w_eff_len = data_len;
    if (data_len < 4'(MIN_DATA_BITS))  w_eff_len = 4'(MIN_DATA_BITS);
    else if (data_len > 4'(DATA_W))    w_eff_len = 4'(DATA_W);
  end

  assign w_eff_osr = (osr_value < OSR_W'(MIN_OSR)) ? OSR_W'(MIN_OSR) : osr_value;
  assign w_mid     = w_eff_osr >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_hist <= 2'b11;
    else if (osr_tick) r_hist <= {r_hist[0], r_rxd_sync};
  end

  // Decision lands on tick mid+1, voting over ticks mid-1, mid and mid+1
  assign w_bit_val  = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxd_sync) | (r_hist[0] & r_rxd_sync);
  assign w_start_pt = w_mid + 1'b1;
`else
  assign w_bit_val  = r_rxd_sync;
  assign w_start_pt = w_mid;
`endif

  // >= rather than == so a mid-frame config change can never strand the counter
  assign w_cnt_next  = r_tick_cnt + 1'b1;
  assign w_run       = enable && rx_enable;
  assign w_fall      = w_run && r_rxd_prev && !r_rxd_sync;
  assign w_start_hit = osr_tick && (w_cnt_next >= w_start_pt);
  assign w_bit_hit   = osr_tick && (w_cnt_next >= w_eff_osr);
  assign w_hit       = (r_state == ST_START) ? w_start_hit : w_bit_hit;
  assign w_last_bit  = (r_bit_idx + 4'd1) >= w_eff_len;
  assign w_brk_now   = r_all_zero && !w_bit_val && !r_stop_idx;
  assign w_push_now  = (r_state == ST_STOP) && w_bit_hit && (w_brk_now || r_stop_idx || !stop_2);
  assign w_err       = rx_err_t'({w_brk_now, r_framing | ~w_bit_val, r_par_err});

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:       if (w_fall) w_state_nx = ST_START;
      ST_START:      if (w_start_hit) w_state_nx = w_bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:       if (w_bit_hit && w_last_bit) w_state_nx = parity_enable ? ST_PARITY : ST_STOP;
      ST_PARITY:     if (w_bit_hit) w_state_nx = ST_STOP;
      ST_STOP: begin
        if (w_bit_hit) begin
          if (w_brk_now)                    w_state_nx = ST_BREAK_WAIT;
          else if (r_stop_idx || !stop_2)   w_state_nx = ST_IDLE;
        end
      end
      ST_BREAK_WAIT: if (r_rxd_sync) w_state_nx = ST_IDLE;
      default:       w_state_nx = ST_IDLE;
    endcase
    if (!w_run) w_state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_rxd_prev <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
      r_rxd_prev <= r_rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_data      <= '0;
      r_par       <= 1'b0;
      r_par_err   <= 1'b0;
      r_framing   <= 1'b0;
      r_all_zero  <= 1'b1;
      r_stop_idx  <= 1'b0;
      r_push_pend <= 1'b0;
      r_entry     <= '0;
    end else begin
      r_push_pend <= w_push_now && w_run;
      if (w_push_now) r_entry <= {w_err, r_data};

      if (r_state == ST_IDLE || r_state == ST_BREAK_WAIT) r_tick_cnt <= '0;
      else if (osr_tick) r_tick_cnt <= w_hit ? '0 : w_cnt_next;

      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_bit_idx  <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_par_err  <= 1'b0;
            r_framing  <= 1'b0;
            r_all_zero <= 1'b1;
            r_stop_idx <= 1'b0;
          end
        end
        ST_DATA: begin
          if (w_bit_hit) begin
            r_data     <= r_data | (DATA_W'(w_bit_val) << r_bit_idx);
            r_bit_idx  <= r_bit_idx + 4'd1;
            r_par      <= r_par ^ w_bit_val;
            r_all_zero <= r_all_zero & ~w_bit_val;
          end
        end
        ST_PARITY: begin
          if (w_bit_hit) begin
            r_par_err  <= w_bit_val != (r_par ^ parity_odd);
            r_all_zero <= r_all_zero & ~w_bit_val;
          end
        end
        ST_STOP: begin
          if (w_bit_hit) begin
            r_framing  <= r_framing | ~w_bit_val;
            r_stop_idx <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_rx_fifo_mem #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (!enable),
    .i_push    (r_push_pend),
    .i_wdata   (r_entry),
    .i_pop     (rd_if.rd_en),
    .o_rdata   (w_rd_entry),
    .o_empty   (rd_if.empty),
    .o_full    (rd_if.full),
    .o_level   (rd_if.level),
    .o_overrun (rd_if.overrun)
  );

  assign rd_if.rd_data = w_rd_entry[DATA_W-1:0];
  assign rd_if.rd_err  = rx_err_t'(w_rd_entry[ENTRY_W-1 -: 3]);
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 9, max data bits per frame (5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter OSR_W, default 8, width of oversampling ratio.
REQ-004 SHALL have clk  in  1  single clock, rising edge.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have enable, rx_enable  in  1 each  block enable, receiver enable.
REQ-007 SHALL have data_len  in  4  data bits per frame.
REQ-008 SHALL have parity_enable, parity_odd, stop_2  in  1 each  frame format.
REQ-009 SHALL have osr_tick  in  1, and osr_value  in  OSR_W  ticks per bit.
REQ-010 SHALL have rxd  in  1  asynchronous serial input.
REQ-011 SHALL have rd_en  in  1  pop head entry.
REQ-012 SHALL have rd_data  out  DATA_W  head data; rd_err  out  3  head flags {break, framing, parity}.
REQ-013 SHALL have empty, full  out  1 each; level  out  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-014 SHALL have overrun  out  1  one-cycle pulse on dropped frame; busy  out  1  FSM not IDLE.

Function
REQ-015 rxd SHALL pass a 2-flop synchronizer (reset 1); all sampling uses the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK_WAIT; busy = state!=IDLE.
REQ-017 data_len <5 SHALL act as 5, >DATA_W as DATA_W; osr_value <4 SHALL act as 4; mid = effective osr_value>>1.
REQ-018 IDLE->START on synchronized falling edge while enable && rx_enable.
REQ-019 START: on the mid-th osr_tick, sample low -> DATA, high -> IDLE (false start, no push).
REQ-020 DATA/PARITY/STOP: each bit sampled every osr_value ticks after the start-bit sample; data LSB first, unused upper rd_data bits zero.
REQ-021 Parity error SHALL be set when sampled parity bit != XOR(data) (even) or != ~XOR(data) (odd); PARITY skipped when parity_enable=0.
REQ-022 Framing error SHALL be set if any stop bit (one, or two when stop_2) samples low.
REQ-023 Break SHALL be set when all data bits, parity bit (if present) and first stop bit are low; FSM then enters BREAK_WAIT, pushes immediately, returns IDLE after rxd high; second stop bit not sampled.
REQ-024 Frame push SHALL occur on the cycle after the final stop-bit sample (or break detection); entry = {flags, data}.
REQ-025 FIFO SHALL be show-ahead: rd_data/rd_err valid whenever empty=0; rd_en while empty ignored.
REQ-026 Push while full and no pop SHALL drop the frame and pulse overrun; push+pop same cycle while full SHALL succeed, level unchanged.
REQ-027 Push+pop same cycle while empty: pop ignored, entry stored, level=1.
REQ-028 rx_enable=0 SHALL force IDLE next cycle, discard partial frame, retain FIFO.
REQ-029 enable=0 SHALL force IDLE and flush FIFO (level 0) next cycle.
REQ-030 Config inputs SHALL be used as sampled each tick; changing them mid-frame yields undefined frame content but no FSM lockup.

Reset
REQ-031 On rst_n low: state IDLE, FIFO empty, level 0, empty=1, full=0, overrun=0, busy=0, rd_data=0, rd_err=0, synchronizer 1.
REQ-032 Reset mid-frame SHALL discard the frame; no push after release.

Configuration
REQ-033 Macro UART_RX_MAJORITY_EN defined: each bit value = majority of synchronized rxd on ticks mid-1, mid, mid+1 of the bit; start validation uses same vote.
REQ-034 Macro undefined: single sample at tick mid; no vote logic built.

Structure
REQ-035 Package uart_pkg SHALL hold the state enum, rx error-flag struct, MIN_DATA_BITS=5, MIN_OSR=4.
REQ-036 FIFO SHALL be sub-module uart_rx_fifo_mem (sync FIFO, show-ahead, level output).

Verification
REQ-037 osr_value=16, tick every cycle, 8N1 0xA5 -> rd_data=0x0A5, rd_err=000, level=1.
REQ-038 7E1 0x41 with parity bit forced 1 -> rd_data=0x041, rd_err=001.
REQ-039 rxd low for 200 bit-times, 8N1 -> one entry data=0x000, rd_err=110, no second entry until rxd high and new start.
REQ-040 FIFO_DEPTH=4, five frames with no reads -> full=1, level=4, overrun pulse once, first four bytes read back in order.
REQ-041 Low glitch of 3 ticks, osr_value=16 -> no push, busy returns 0.
REQ-042 rx_enable dropped mid-data after two queued bytes -> busy=0 next cycle, level=2 kept; enable dropped -> level=0.
